// File: rtl/fb_pkg.sv
// Shared constants for the framebuffer fill engine: geometry defaults,
// CPU register map, CTRL/STATUS bit positions and the engine state encoding.
package fb_pkg;

  localparam int FB_WORDS = 32768;
  localparam int ADDR_W   = 15;

  localparam logic [2:0] REG_START   = 3'd0;
  localparam logic [2:0] REG_COUNT   = 3'd1;
  localparam logic [2:0] REG_PATTERN = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_INCR   = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_REM_LSB = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/fb_fill_engine.sv
// Fills a run of framebuffer words with a constant or incrementing pattern,
// one word per cycle while fb_ready is high; holds the request stable on stalls.
module fb_fill_engine #(
  parameter int FB_WORDS = fb_pkg::FB_WORDS,
  parameter int ADDR_W   = fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [2:0]        address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic              fb_chipselect,
  output logic              fb_write,
  output logic [ADDR_W-1:0] fb_address,
  output logic [31:0]       fb_writedata,
  input  logic              fb_ready
);
  import fb_pkg::*;

  state_e            state_q;
  logic [ADDR_W-1:0] start_q, addr_q, addr_d;
  logic [16:0]       count_q, rem_q;
  logic [31:0]       pattern_q, data_q, data_d, readdata_q, rd_mux;
  logic              incr_q, irq_en_q, done_q, err_q, fb_write_q;

  logic cpu_wr, cpu_rd, wr_ctrl, busy, go, abort, accept, bad_count;

  assign cpu_wr    = chipselect & write;
  assign cpu_rd    = chipselect & read;
  assign wr_ctrl   = cpu_wr && (address == REG_CTRL);
  assign busy      = (state_q != IDLE);
  assign go        = wr_ctrl && writedata[CTRL_GO] && (state_q == IDLE);
  assign abort     = wr_ctrl && writedata[CTRL_ABORT] && (state_q == RUN);
  assign accept    = fb_write_q && fb_ready;
  assign bad_count = (count_q == 17'd0) || (int'(count_q) > FB_WORDS);

  // Address wraps at the framebuffer depth, not at the power of two above it.
  assign addr_d = (addr_q == ADDR_W'(FB_WORDS - 1)) ? '0 : addr_q + 1'b1;
  assign data_d = incr_q ? data_q + 32'd1 : data_q;

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_START:   rd_mux = {{(32-ADDR_W){1'b0}}, start_q};
      REG_COUNT:   rd_mux = {15'd0, count_q};
      REG_PATTERN: rd_mux = pattern_q;
      REG_CTRL:    rd_mux = {28'd0, irq_en_q, 1'b0, incr_q, 1'b0};
      REG_STATUS:  rd_mux = {rem_q[15:0], 13'd0, err_q, done_q, busy};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      start_q    <= '0;
      count_q    <= '0;
      pattern_q  <= '0;
      incr_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rem_q      <= '0;
      fb_write_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      if (cpu_rd) readdata_q <= rd_mux;

      if (cpu_wr && !busy) begin
        case (address)
          REG_START:   start_q   <= writedata[ADDR_W-1:0];
          REG_COUNT:   count_q   <= writedata[16:0];
          REG_PATTERN: pattern_q <= writedata;
          default: ;
        endcase
      end

      if (wr_ctrl) begin
        irq_en_q <= writedata[CTRL_IRQ_EN];
        if (!busy) incr_q <= writedata[CTRL_INCR];
      end

      // Read-to-clear; later assignments below (GO, abort, finish) take priority.
      if (cpu_rd && (address == REG_STATUS) && !go) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (go) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bad_count) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              addr_q     <= start_q;
              data_q     <= pattern_q;
              rem_q      <= count_q;
              fb_write_q <= 1'b1;
              state_q    <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            addr_q <= addr_d;
            data_q <= data_d;
            rem_q  <= rem_q - 17'd1;
          end
          if (abort) begin
            fb_write_q <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            state_q    <= IDLE;
          end else if (accept && (rem_q == 17'd1)) begin
            fb_write_q <= 1'b0;
            state_q    <= FINISH;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readdata      = readdata_q;
  assign irq           = done_q & irq_en_q;
  assign fb_write      = fb_write_q;
  assign fb_chipselect = fb_write_q;
  assign fb_address    = addr_q;
  assign fb_writedata  = data_q;

endmodule

// File: doc/fb_fill_engine.md
FB_FILL_ENGINE -- requirements
Module: fb_fill_engine

Interface
REQ-001 SHALL have parameter FB_WORDS, default 32768, meaning framebuffer depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 15, meaning framebuffer word-address width (log2 FB_WORDS).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port chipselect  input  1  CPU slave select.
REQ-006 SHALL have port write  input  1  CPU register write strobe, qualified by chipselect.
REQ-007 SHALL have port read  input  1  CPU register read strobe, qualified by chipselect.
REQ-008 SHALL have port address  input  3  CPU register index.
REQ-009 SHALL have port writedata  input  32  CPU write data.
REQ-010 SHALL have port readdata  output  32  CPU read data, registered, valid the cycle after read.
REQ-011 SHALL have port irq  output  1  level interrupt, high while DONE=1 and IRQ_EN=1.
REQ-012 SHALL have port fb_chipselect  output  1  framebuffer select, equal to fb_write.
REQ-013 SHALL have port fb_write  output  1  framebuffer write request.
REQ-014 SHALL have port fb_address  output  ADDR_W  framebuffer word address.
REQ-015 SHALL have port fb_writedata  output  32  framebuffer word data.
REQ-016 SHALL have port fb_ready  input  1  framebuffer accepts the word when fb_write and fb_ready are both high.

Function
REQ-017 SHALL map registers: 0 START (bits ADDR_W-1:0), 1 COUNT (bits 16:0), 2 PATTERN (32), 3 CTRL (bit0 GO, bit1 INCR, bit2 ABORT, bit3 IRQ_EN), 4 STATUS (bit0 BUSY, bit1 DONE, bit2 ERR, bits 31:16 words remaining); other indices read 0.
REQ-018 SHALL implement FSM states IDLE, RUN, FINISH.
REQ-019 In IDLE, a write of CTRL with GO=1 SHALL clear DONE and ERR; if COUNT is 0 or above FB_WORDS, set ERR and DONE and stay in IDLE; otherwise load address=START, data=PATTERN, remaining=COUNT, and enter RUN.
REQ-020 fb_write SHALL assert the cycle after the GO write, with fb_address=START and fb_writedata=PATTERN.
REQ-021 In RUN, while fb_ready=0, fb_write, fb_address and fb_writedata SHALL hold stable.
REQ-022 On each accepted word: remaining decrements; address increments modulo FB_WORDS (FB_WORDS-1 wraps to 0); data increments by 1 modulo 2^32 if INCR=1, else it is unchanged.
REQ-023 Acceptance of the last word (remaining=1) SHALL deassert fb_write in the following cycle and enter FINISH; FINISH sets DONE and returns to IDLE in one cycle.
REQ-024 With fb_ready held high, throughput SHALL be one word per cycle and COUNT=N SHALL give exactly N accepted writes.
REQ-025 A CTRL write with ABORT=1 in RUN SHALL deassert fb_write the next cycle, set DONE and ERR, and enter IDLE; a word accepted in the same cycle as the ABORT write counts as written.
REQ-026 Writes to START, COUNT, PATTERN, or CTRL with GO=1 while BUSY SHALL be ignored; IRQ_EN updates are accepted at any time.
REQ-027 A STATUS read SHALL clear DONE and ERR, unless GO fires in the same cycle.
REQ-028 BUSY SHALL be 1 exactly in RUN and FINISH.

Reset
REQ-029 When reset=0 at a clock edge, the block SHALL enter IDLE, clear all registers, remaining and status bits to 0, and drive fb_write, fb_chipselect, fb_address, fb_writedata, readdata and irq to 0.
REQ-030 Reset asserted during RUN SHALL drop fb_write at the next edge, and no further words SHALL be issued.

Structure
REQ-031 Package fb_pkg SHALL hold FB_WORDS, ADDR_W, the register index constants, CTRL/STATUS bit positions, and the FSM state enum.
REQ-032 The block SHALL be one module with no sub-modules; its fb_* ports connect directly to the display controller's write port.

Verification
REQ-033 START=0, COUNT=32768, PATTERN=FFFFFFFF, fb_ready=1 -> 32768 writes to addresses 0..7FFF on consecutive cycles, then DONE=1.
REQ-034 START=7FFE, COUNT=4, INCR=1, PATTERN=FFFFFFFE -> addresses 7FFE, 7FFF, 0000, 0001 with data FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-035 COUNT=3, fb_ready toggled 0,0,1,0,1,1 -> fb_address and fb_writedata stable through stalls; exactly 3 accepts.
REQ-036 COUNT=0 then GO -> no fb_write; STATUS reads ERR=1, DONE=1; a second STATUS read returns 0.
REQ-037 COUNT=100, ABORT after the 10th accept -> 10 or 11 writes total, ERR=1, irq=1 with IRQ_EN=1.
REQ-038 reset=0 for one cycle during RUN -> fb_write=0 the next cycle; all STATUS fields 0.
